// File: rtl/multi_digit_counter.sv
// Cascaded multi-digit BCD-style counter with load, up/down, wrap/saturate modes.
// All digits update on the same edge; terminal flags are decoded from count.
module multi_digit_counter #(
   parameter int unsigned DIGITS = 2,
   parameter int unsigned MAX    = 10,
   parameter int unsigned WIDTH  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    up,
   input  logic                    sat_mode,
   input  logic                    load,
   input  logic [DIGITS*WIDTH-1:0] load_val,
   output logic [DIGITS*WIDTH-1:0] count,
   output logic                    carry,
   output logic                    at_max,
   output logic                    at_zero
);

   localparam int unsigned CW = DIGITS * WIDTH;
   localparam logic [WIDTH-1:0] MAX_D = WIDTH'(MAX);

   generate
      if (MAX < 1 || DIGITS < 1 || WIDTH < $clog2(MAX + 1)) begin : g_bad_cfg
         $error("multi_digit_counter: invalid DIGITS/MAX/WIDTH configuration");
      end
   endgenerate

   logic [CW-1:0]    load_clean;
   logic [CW-1:0]    stepped;
   logic [CW-1:0]    count_nxt;
   logic             carry_nxt;
   logic             max_below;
   logic             zero_below;
   logic             ends;
   logic [WIDTH-1:0] d;

   // Out-of-range load digits are cleared, valid ones pass through.
   always_comb begin
      load_clean = '0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         load_clean[k*WIDTH +: WIDTH] =
            (load_val[k*WIDTH +: WIDTH] > MAX_D) ? '0 : load_val[k*WIDTH +: WIDTH];
      end
   end

   // Parallel step: each digit looks at the all-MAX / all-zero prefix below it.
   always_comb begin
      stepped    = count;
      max_below  = 1'b1;
      zero_below = 1'b1;
      d          = '0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         d = count[k*WIDTH +: WIDTH];
         if (d > MAX_D) begin
            stepped[k*WIDTH +: WIDTH] = '0;
         end else if (up && max_below) begin
            stepped[k*WIDTH +: WIDTH] = (d == MAX_D) ? '0 : d + WIDTH'(1);
         end else if (!up && zero_below) begin
            stepped[k*WIDTH +: WIDTH] = (d == '0) ? MAX_D : d - WIDTH'(1);
         end
         max_below  = max_below  & (d == MAX_D);
         zero_below = zero_below & (d == '0);
      end
   end

   assign at_max  = max_below;
   assign at_zero = zero_below;
   assign ends    = up ? max_below : zero_below;

   // Next-state selection: load beats en; saturation suppresses the end step.
   always_comb begin
      count_nxt = count;
      carry_nxt = 1'b0;
      if (load) begin
         count_nxt = load_clean;
      end else if (en && !(sat_mode && ends)) begin
         count_nxt = stepped;
         carry_nxt = ends;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         carry <= 1'b0;
      end else begin
         count <= count_nxt;
         carry <= carry_nxt;
      end
   end

endmodule

// File: doc/multi_digit_counter.md
MULTI_DIGIT_COUNTER -- requirements
Module: multi_digit_counter

Interface
REQ-001 Parameter DIGITS, default 2: number of cascaded digits.
REQ-002 Parameter MAX, default 10: terminal value of each digit; each digit counts 0..MAX, so the modulus is MAX+1.
REQ-003 Parameter WIDTH, default 4: bits per digit; configurations with WIDTH < clog2(MAX+1), MAX < 1 or DIGITS < 1 SHALL fail elaboration.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  count enable; one step per cycle when high.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 sat_mode  input  1  1 = saturate at range ends, 0 = wrap around.
REQ-009 load  input  1  synchronous parallel load strobe.
REQ-010 load_val  input  DIGITS*WIDTH  load value; digit k occupies bits [k*WIDTH +: WIDTH], digit 0 is least significant.
REQ-011 count  output  DIGITS*WIDTH  registered counter value, same digit packing as load_val.
REQ-012 carry  output  1  registered one-cycle pulse on full-range wrap, in either direction.
REQ-013 at_max  output  1  high when every digit equals MAX; decoded combinationally from count.
REQ-014 at_zero  output  1  high when every digit equals 0; decoded combinationally from count.

Function
REQ-015 Priority each cycle SHALL be reset > load > en; with none of these asserted, count holds and carry is 0.
REQ-016 Load: count <= load_val; any digit of load_val greater than MAX SHALL load as 0, while other digits load unchanged; carry is 0 in a load cycle.
REQ-017 Up step: digit 0 increments; digit k (k>0) steps only when digits 0..k-1 all equal MAX; a stepping digit at MAX becomes 0, otherwise it becomes value+1.
REQ-018 Down step: digit 0 decrements; digit k (k>0) steps only when digits 0..k-1 all equal 0; a stepping digit at 0 becomes MAX, otherwise it becomes value-1.
REQ-019 All digit updates SHALL occur in the same clock edge, giving a latency of 1 cycle from en to the new count, with no ripple delay between digits.
REQ-020 Wrap, sat_mode=0: stepping up from all-MAX gives all-0, and stepping down from all-0 gives all-MAX; carry=1 in the cycle the wrapped value is first presented, and 0 otherwise.
REQ-021 Saturate, sat_mode=1: an up step at all-MAX, or a down step at all-0, SHALL hold count and keep carry=0; steps away from the ends behave as in REQ-017/REQ-018.
REQ-022 Any digit found holding a value greater than MAX during a step SHALL become 0 on that edge, regardless of direction.
REQ-023 Changing up or sat_mode between cycles SHALL take effect on the next edge, with no dead cycle.
REQ-024 With DIGITS=1, MAX=10, en=1, up=1 and sat_mode=0, the block SHALL count 0,1,...,10,0 repeating.

Reset
REQ-025 While reset=1 at posedge clk: count <= 0 and carry <= 0, overriding load and en.
REQ-026 After reset, at_zero=1 and at_max=0; counting resumes on the first edge with reset=0 and en=1.

Verification (defaults DIGITS=2, MAX=10, WIDTH=4; values shown as {digit1,digit0})
REQ-027 Reset, then en=1, up=1 for 11 cycles -> digit0 steps 1..10, then count={1,0}; carry stays 0.
REQ-028 Load {10,10}, then en=1, up=1, sat_mode=0 for one cycle -> count={0,0} and carry=1 for exactly one cycle; at_zero=1.
REQ-029 Load {1,0}, then down 1 step -> {0,10}; continue down 10 steps -> {0,0}; one more step -> {10,10} with carry=1.
REQ-030 sat_mode=1: at {10,10} step up 3 cycles -> stays {10,10}, carry=0; at {0,0} step down -> stays {0,0}.
REQ-031 load=1 with load_val={12,3} and en=1 in the same cycle -> count={0,3} and carry=0, i.e. load wins and the invalid digit is cleared.
REQ-032 Mid-count at {5,7}, assert reset together with load=1 and en=1 -> count={0,0}, carry=0; release reset -> counting resumes from {0,0}.
